// File: rtl/rco_event_fifo_pkg.sv
// Shared record layout and mode codes for the MODO counter and its event FIFO.
// Holds the field widths every rco_event_fifo file agrees on.
package rco_event_fifo_pkg;

    localparam int MODO_W = 2;
    localparam int Q_W    = 4;
    localparam int REC_W  = MODO_W + Q_W;

    typedef enum logic [MODO_W-1:0] {
        MODE_UP   = 2'b00,
        MODE_DOWN = 2'b01,
        MODE_UP3  = 2'b10,
        MODE_LOAD = 2'b11
    } modo_e;

    typedef struct packed {
        logic [MODO_W-1:0] modo;
        logic [Q_W-1:0]    q;
    } rec_t;

    function automatic rec_t make_rec(input logic [MODO_W-1:0] modo,
                                      input logic [Q_W-1:0]    q);
        rec_t rec;
        rec.modo = modo;
        rec.q    = q;
        return rec;
    endfunction

endpackage

// File: rtl/rco_event_fifo_if.sv
// Bundle between the MODO counter/host side (master) and rco_event_fifo (slave).
// Carries the counter snapshot inputs plus the pop/status/readback signals.
interface rco_event_fifo_if
    import rco_event_fifo_pkg::*;
#(
    parameter int AW    = 2,
    parameter int CNT_W = 8
);
    logic              enable;
    logic [MODO_W-1:0] modo;
    logic [Q_W-1:0]    q;
    logic              rco;
    logic              rd_en;
    logic              clr_ovf;
    logic [REC_W-1:0]  rd_data;
    logic              rd_valid;
    logic              empty;
    logic              full;
    logic [AW:0]       level;
    logic              ovf;
    logic [CNT_W-1:0]  evt_cnt;

    modport master (
        output enable, modo, q, rco, rd_en, clr_ovf,
        input  rd_data, rd_valid, empty, full, level, ovf, evt_cnt
    );

    modport slave (
        input  enable, modo, q, rco, rd_en, clr_ovf,
        output rd_data, rd_valid, empty, full, level, ovf, evt_cnt
    );

endinterface

// File: rtl/rco_event_fifo_evt_fifo.sv
// Synchronous record FIFO: registered read port, count-based level, full-with-pop accepts push.
// Push and pop on an empty FIFO store the push and ignore the pop (no bypass).
module rco_event_fifo_evt_fifo
    import rco_event_fifo_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        rd_en,
    input  rec_t        wr_data,
    output rec_t        rd_data,
    output logic        rd_valid,
    output logic        empty,
    output logic        full,
    output logic [AW:0] level
);

    rec_t          mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    rec_t          rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic          push_ok, pop_ok;

    // NOTE: every _d is assigned a default first, so no path leaves it unassigned and no latch appears.
    always_comb begin
        pop_ok     = rd_en & ~empty_q;
        push_ok    = push & (~full_q | rd_en);
        wr_ptr_d   = wr_ptr_q + AW'(push_ok);
        rd_ptr_d   = rd_ptr_q + AW'(pop_ok);
        level_d    = level_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        empty_d    = (level_d == '0);
        full_d     = (level_d == (AW+1)'(DEPTH));
        rd_data_d  = rd_data_q;
        rd_valid_d = pop_ok;
        if (pop_ok) begin
            rd_data_d = mem_q[rd_ptr_q];
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // NOTE: the storage array has no reset; entries are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign empty    = empty_q;
    assign full     = full_q;
    assign level    = level_q;

endmodule

// File: rtl/rco_event_fifo.sv
// Captures {modo,q} on each qualified MODO rco pulse; tracks event count and sticky overflow.
// Define RCO_EDGE_EN to qualify only the rising edge of rco (one record per rco high run).
module rco_event_fifo
    import rco_event_fifo_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    rco_event_fifo_if.slave   bus
);

    logic             push_req;
    logic             drop;
    logic             fifo_full;
    logic [CNT_W-1:0] evt_cnt_q, evt_cnt_d;
    logic             ovf_q, ovf_d;
    rec_t             fifo_rd_data;

`ifdef RCO_EDGE_EN
    logic rco_dly_q, rco_dly_d;

    always_comb begin
        rco_dly_d = bus.rco;
        push_req  = bus.enable & bus.rco & ~rco_dly_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rco_dly_q <= 1'b0;
        end else begin
            rco_dly_q <= rco_dly_d;
        end
    end
`else
    always_comb begin
        push_req = bus.enable & bus.rco;
    end
`endif

    // A full FIFO still accepts the push when the same edge pops a slot free.
    always_comb begin
        drop      = push_req & fifo_full & ~bus.rd_en;
        evt_cnt_d = evt_cnt_q + CNT_W'(push_req);
        ovf_d     = ovf_q;
        if (bus.clr_ovf) begin
            ovf_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_cnt_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            evt_cnt_q <= evt_cnt_d;
            ovf_q     <= ovf_d;
        end
    end

    rco_event_fifo_evt_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push_req),
        .rd_en    (bus.rd_en),
        .wr_data  (make_rec(bus.modo, bus.q)),
        .rd_data  (fifo_rd_data),
        .rd_valid (bus.rd_valid),
        .empty    (bus.empty),
        .full     (fifo_full),
        .level    (bus.level)
    );

    assign bus.rd_data = fifo_rd_data;
    assign bus.full    = fifo_full;
    assign bus.ovf     = ovf_q;
    assign bus.evt_cnt = evt_cnt_q;

endmodule

// File: tb/tb_rco_event_fifo.sv
// Directed bench for rco_event_fifo: popped records are checked by a scoreboard monitor,
// status outputs (level/full/empty/ovf/evt_cnt) by direct checks after each edge.
module tb_rco_event_fifo;
    import rco_event_fifo_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_passed;
    logic [5:0] exp_q [$];

    rco_event_fifo_if #(.AW(2), .CNT_W(8)) bus ();

    rco_event_fifo #(.DEPTH(4), .AW(2), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_passed++;
        end
    endtask

    // Monitor: every rd_valid pulse must match the oldest outstanding expected record.
    always @(negedge clk) begin
        if (!rst && bus.rd_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_rd_valid: got rd_data %0h expected no output (t=%0t)",
                         bus.rd_data, $time);
            end else begin
                check("rd_data", 32'(bus.rd_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.enable  = 1'b0;
        bus.rco     = 1'b0;
        bus.rd_en   = 1'b0;
        bus.clr_ovf = 1'b0;
    endtask

    // One rco pulse followed by a quiet cycle, so edge-qualified builds see a fresh edge.
    task automatic push_one(input logic [1:0] m, input logic [3:0] qv);
        bus.enable = 1'b1;
        bus.modo   = m;
        bus.q      = qv;
        bus.rco    = 1'b1;
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic pop_expect(input logic [5:0] e);
        exp_q.push_back(e);
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
    endtask

    initial begin
        int n_t6;
        n_checks = 0;
        n_passed = 0;
        rst      = 1'b1;
        bus.modo = MODE_UP;
        bus.q    = 4'h0;
        idle_inputs();
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_level",    32'(bus.level),    0);
        check("rst_empty",    32'(bus.empty),    1);
        check("rst_full",     32'(bus.full),     0);
        check("rst_ovf",      32'(bus.ovf),      0);
        check("rst_evt_cnt",  32'(bus.evt_cnt),  0);
        check("rst_rd_valid", 32'(bus.rd_valid), 0);
        check("rst_rd_data",  32'(bus.rd_data),  0);

        // T2: count up to 1111, rco only on the terminal count
        bus.enable = 1'b1;
        bus.modo   = MODE_UP;
        for (int i = 12; i < 16; i++) begin
            bus.q   = 4'(i);
            bus.rco = (i == 15);
            tick();
        end
        idle_inputs();
        check("t2_level",   32'(bus.level),   1);
        check("t2_evt_cnt", 32'(bus.evt_cnt), 1);
        pop_expect(6'h0F);
        check("t2_rd_valid", 32'(bus.rd_valid), 1);
        check("t2_rd_data",  32'(bus.rd_data),  32'h0F);
        check("t2_empty",    32'(bus.empty),    1);
        tick();
        check("t2_rd_valid_pulse", 32'(bus.rd_valid), 0);

        // T3: fill past capacity, then clear the sticky overflow
        for (int i = 1; i <= 4; i++) push_one(MODE_DOWN, 4'(i));
        check("t3_full",     32'(bus.full),  1);
        check("t3_level",    32'(bus.level), 4);
        check("t3_ovf_pre",  32'(bus.ovf),   0);
        push_one(MODE_DOWN, 4'h5);
        check("t3_ovf",      32'(bus.ovf),     1);
        check("t3_evt_cnt",  32'(bus.evt_cnt), 6);
        check("t3_level_hold", 32'(bus.level), 4);
        bus.clr_ovf = 1'b1;
        tick();
        bus.clr_ovf = 1'b0;
        check("t3_ovf_clr", 32'(bus.ovf), 0);

        // T4: full + push + pop in one cycle
        exp_q.push_back(6'h11);
        bus.enable = 1'b1;
        bus.modo   = MODE_UP3;
        bus.q      = 4'h6;
        bus.rco    = 1'b1;
        bus.rd_en  = 1'b1;
        tick();
        idle_inputs();
        check("t4_level",   32'(bus.level),   4);
        check("t4_ovf",     32'(bus.ovf),     0);
        check("t4_full",    32'(bus.full),    1);
        check("t4_evt_cnt", 32'(bus.evt_cnt), 7);
        tick();
        pop_expect(6'h12);
        pop_expect(6'h13);
        pop_expect(6'h14);
        pop_expect(6'h26);
        check("t4_drained", 32'(bus.empty), 1);

        // T5: pop while empty, then push+pop on empty
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        check("t5_rd_valid", 32'(bus.rd_valid), 0);
        check("t5_rd_hold",  32'(bus.rd_data),  32'h26);
        bus.enable = 1'b1;
        bus.modo   = MODE_LOAD;
        bus.q      = 4'h9;
        bus.rco    = 1'b1;
        bus.rd_en  = 1'b1;
        tick();
        idle_inputs();
        check("t5_level",     32'(bus.level),    1);
        check("t5_no_output", 32'(bus.rd_valid), 0);
        pop_expect(6'h39);
        tick();

        // T6: rco held high three cycles, with and without enable
`ifdef RCO_EDGE_EN
        n_t6 = 1;
`else
        n_t6 = 3;
`endif
        bus.enable = 1'b1;
        bus.modo   = MODE_UP;
        for (int i = 0; i < 3; i++) begin
            bus.q   = 4'(10 + i);
            bus.rco = 1'b1;
            tick();
        end
        idle_inputs();
        check("t6_level",   32'(bus.level),   32'(n_t6));
        check("t6_evt_cnt", 32'(bus.evt_cnt), 32'(8 + n_t6));
        for (int i = 0; i < 3; i++) begin
            bus.q   = 4'(3 + i);
            bus.rco = 1'b1;
            tick();
        end
        idle_inputs();
        check("t6_dis_level",   32'(bus.level),   32'(n_t6));
        check("t6_dis_evt_cnt", 32'(bus.evt_cnt), 32'(8 + n_t6));
        for (int i = 0; i < n_t6; i++) pop_expect(6'(8'h0A + i));
        tick();

        // T1: reset mid-stream with level=3 and ovf set
        for (int i = 1; i <= 5; i++) push_one(MODE_UP3, 4'(i));
        pop_expect(6'h21);
        tick();
        check("t1_pre_level", 32'(bus.level), 3);
        check("t1_pre_ovf",   32'(bus.ovf),   1);
        rst = 1'b1;
        #1;
        check("t1_level",    32'(bus.level),    0);
        check("t1_empty",    32'(bus.empty),    1);
        check("t1_ovf",      32'(bus.ovf),      0);
        check("t1_evt_cnt",  32'(bus.evt_cnt),  0);
        check("t1_rd_valid", 32'(bus.rd_valid), 0);
        tick();
        rst = 1'b0;
        tick();

        // evt_cnt wrap: 256 requests return it to 0; only the first four are stored
        for (int i = 0; i < 256; i++) push_one(MODE_UP, 4'(i));
        check("wrap_evt_cnt", 32'(bus.evt_cnt), 0);
        check("wrap_level",   32'(bus.level),   4);
        check("wrap_ovf",     32'(bus.ovf),     1);
        for (int i = 0; i < 4; i++) pop_expect(6'(i));
        tick();
        tick();
        check("exp_q_drained", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
